// File: rtl/rotor_step_ctrl.sv
// Rotor stepping controller: loads initial rotor positions and
// advances them once per accepted key, with notch carry and double-step.
module rotor_step_ctrl #(
  parameter int unsigned NOTCH_0 = 16,
  parameter int unsigned NOTCH_1 = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [4:0] pozitie_initiala_0,
  input  logic [4:0] pozitie_initiala_1,
  input  logic [4:0] pozitie_initiala_2,
  input  logic       key_valid,
  output logic       key_ready,
  output logic [4:0] pozitie_0,
  output logic [4:0] pozitie_1,
  output logic [4:0] pozitie_2,
  output logic       pos_valid,
  output logic       cfg_err
);

  localparam logic [4:0] N0 = 5'(NOTCH_0);
  localparam logic [4:0] N1 = 5'(NOTCH_1);

  typedef enum logic [1:0] {
    S_UNCFG = 2'd0,
    S_IDLE  = 2'd1,
    S_BUSY  = 2'd2
  } state_t;

  state_t     state_q;
  logic [4:0] p0_q, p1_q, p2_q;
  logic [4:0] p0_d, p1_d, p2_d;
  logic [4:0] l0_d, l1_d, l2_d;
  logic       err_d;
  logic       ready_q, pv_q, err_q;
  logic       c1, d1;

  function automatic logic [4:0] inc26(input logic [4:0] v);
    return (v == 5'd25) ? 5'd0 : v + 5'd1;
  endfunction

  function automatic logic [4:0] clamp(input logic [4:0] v);
    return (v > 5'd25) ? 5'd0 : v;
  endfunction

  // Stepped positions from the pre-step values, and sanitized load values.
  always_comb begin
    c1    = (p0_q == N0);
    d1    = (p1_q == N1);
    p0_d  = inc26(p0_q);
    p1_d  = (c1 || d1) ? inc26(p1_q) : p1_q;
    p2_d  = d1 ? inc26(p2_q) : p2_q;
    l0_d  = clamp(pozitie_initiala_0);
    l1_d  = clamp(pozitie_initiala_1);
    l2_d  = clamp(pozitie_initiala_2);
    err_d = (pozitie_initiala_0 > 5'd25) ||
            (pozitie_initiala_1 > 5'd25) ||
            (pozitie_initiala_2 > 5'd25);
  end

  // Control FSM with registered handshake and position outputs; load wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_UNCFG;
      p0_q    <= 5'd0;
      p1_q    <= 5'd0;
      p2_q    <= 5'd0;
      ready_q <= 1'b0;
      pv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else if (load) begin
      state_q <= S_IDLE;
      p0_q    <= l0_d;
      p1_q    <= l1_d;
      p2_q    <= l2_d;
      ready_q <= 1'b1;
      pv_q    <= 1'b0;
      err_q   <= err_d;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (key_valid) begin
            state_q <= S_BUSY;
            p0_q    <= p0_d;
            p1_q    <= p1_d;
            p2_q    <= p2_d;
            ready_q <= 1'b0;
            pv_q    <= 1'b1;
          end
        end
        S_BUSY: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
          pv_q    <= 1'b0;
        end
        default: begin
          state_q <= S_UNCFG;
          ready_q <= 1'b0;
          pv_q    <= 1'b0;
        end
      endcase
    end
  end

  assign key_ready = ready_q;
  assign pos_valid = pv_q;
  assign cfg_err   = err_q;
  assign pozitie_0 = p0_q;
  assign pozitie_1 = p1_q;
  assign pozitie_2 = p2_q;

endmodule
